// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants.
// Used by the fetch stage and its pipeline register.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] PC_STEP           = 32'd4;
    localparam logic [WORD_W-1:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
        logic              valid;
    } if_id_t;

    function automatic logic [WORD_W-1:0] word_align(
        input logic [WORD_W-1:0] addr
    );
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, imem port, IF/ID outputs.
// master = fetch unit, slave = surrounding datapath.
interface instruction_fetch_unit_if;
    import mips_pkg::*;

    logic              stall;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] if_id_instr;
    logic [WORD_W-1:0] if_id_pc_plus4;
    logic              if_id_valid;
    logic              halted;
    logic [WORD_W-1:0] fetch_count;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        output imem_addr,
        output if_id_instr,
        output if_id_pc_plus4,
        output if_id_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        input  imem_addr,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  if_id_valid,
        input  halted,
        input  fetch_count
    );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register with load, hold and flush controls.
// Flush wins over load so a redirect never lets a stale word through.
module if_id_register
    import mips_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t data_q;
    if_id_t data_d;

    always_comb begin
        data_d = data_q;
        if (flush_i) begin
            data_d = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, run/halt FSM, fetch counter and IF/ID register.
// Redirect beats stall, stall beats halt detection, halt beats a normal fetch.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input logic                      clk,
    input logic                      reset_n,
    instruction_fetch_unit_if.master fetch
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] cnt_d;
    logic [WORD_W-1:0] pc_plus4;

    logic   is_halt;
    logic   take_redir;
    logic   take_stall;
    logic   take_halt;
    logic   take_fetch;
    logic   ifid_load;
    logic   ifid_flush;
    if_id_t ifid_d;
    if_id_t ifid_q;

    assign pc_plus4 = pc_q + PC_STEP;
    assign is_halt  = (fetch.imem_rdata == HALT_WORD);

    // One-hot decode of the per-edge priority while running.
    assign take_redir = fetch.redirect_valid;
    assign take_stall = !fetch.redirect_valid && fetch.stall;
    assign take_halt  = !fetch.redirect_valid && !fetch.stall && is_halt;
    assign take_fetch = !fetch.redirect_valid && !fetch.stall && !is_halt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_RUN: begin
                if (take_halt) begin
                    state_d = FS_HALTED;
                end
            end
            FS_HALTED: begin
                state_d = FS_HALTED;
            end
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            FS_RUN: begin
                unique case (1'b1)
                    take_redir: begin
                        pc_d       = word_align(fetch.redirect_pc);
                        ifid_flush = 1'b1;
                    end
                    take_stall: begin
                        pc_d = pc_q;
                    end
                    take_halt: begin
                        ifid_flush = 1'b1;
                    end
                    take_fetch: begin
                        pc_d      = pc_plus4;
                        cnt_d     = cnt_q + 32'd1;
                        ifid_load = 1'b1;
                    end
                endcase
            end
            FS_HALTED: begin
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign ifid_d = '{
        instr:    fetch.imem_rdata,
        pc_plus4: pc_plus4,
        valid:    1'b1
    };

    if_id_register u_if_id (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign fetch.imem_addr      = word_align(pc_q);
    assign fetch.if_id_instr    = ifid_q.instr;
    assign fetch.if_id_pc_plus4 = ifid_q.pc_plus4;
    assign fetch.if_id_valid    = ifid_q.valid;
    assign fetch.halted         = (state_q == FS_HALTED);
    assign fetch.fetch_count    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios
// followed by randomized stall/redirect/halt traffic.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic inj_halt;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fetch   (bus)
    );

    logic [31:0] mem [logic [31:0]];
    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic        st_edge = 1'b0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_halted;
    bit          m_valid;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        if (mem.exists(a)) return mem[a];
        w = (a ^ 32'h5A5A_0000) * 32'h9E37_79B1;
        if (w == HALT) w = 32'h0000_0013;
        return w;
    endfunction

    assign bus.imem_rdata = inj_halt ? HALT : word_at(bus.imem_addr);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) st_edge = bus.stall;

    // A new delivery is a valid IF/ID word after an unstalled edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.if_id_valid === 1'b1 && !st_edge) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got instr %h expected none",
                         bus.if_id_instr);
            end else begin
                mon_e = q.pop_front();
                chk("if_id_instr", bus.if_id_instr, mon_e.instr);
                chk("if_id_pc_plus4", bus.if_id_pc_plus4, mon_e.pc4);
                chk("deliv_count", bus.fetch_count, mon_e.cnt);
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(bit st, bit rd, logic [31:0] rpc, bit hi);
        logic [31:0] w;
        bus.stall          = st;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        inj_halt           = hi;
        w = hi ? HALT : word_at(m_pc);
        if (m_halted) begin
            m_valid = 0;
        end else if (rd) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_valid = 0;
        end else if (st) begin
            m_valid = m_valid;
        end else if (w == HALT) begin
            m_halted = 1;
            m_valid  = 0;
        end else begin
            m_cnt = m_cnt + 32'd1;
            q.push_back('{w, m_pc + 32'd4, m_cnt});
            m_pc    = m_pc + 32'd4;
            m_valid = 1;
        end
        @(posedge clk);
        #1;
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
        chk("fetch_count", bus.fetch_count, m_cnt);
        if (!m_valid) chk("flushed_instr", bus.if_id_instr, 32'h0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset_n            = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        inj_halt           = 1'b0;
        #1;
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_instr", bus.if_id_instr, 32'h0);
        chk("rst_pc_plus4", bus.if_id_pc_plus4, 32'h0);
        chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_count", bus.fetch_count, 32'h0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        q.delete();
        m_pc     = 32'h0;
        m_cnt    = 32'h0;
        m_halted = 0;
        m_valid  = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n            = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        inj_halt           = 1'b0;
        mem[32'h0]  = 32'h2008_0005;
        mem[32'h4]  = 32'h2009_0003;
        mem[32'h14] = HALT;
        @(negedge clk);
        do_reset();

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h43, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h10, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        do_reset();
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        do_reset();
        step(0, 1, 32'hFFFF_FFFE, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < (m_halted ? 10 : 1)) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom(),
                     $urandom_range(0, 29) == 0);
            end
        end

        #1;
        chk("final_queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
